// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared types, default widths and helpers for the sequential signed divider.
//   div_state_t : controller states (IDLE -> CALC -> DONE -> IDLE)
//   DIV_N_W     : default dividend/quotient width
//   DIV_D_W     : default divisor/remainder width
//   DIV_BPC     : default quotient bits resolved per CALC cycle
//   abs_n()     : two's-complement magnitude, computed on a wide container so
//                 the most negative value of any narrower width is exact
// -----------------------------------------------------------------------------
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DIV_N_W = 32;
    localparam int DIV_D_W = 16;
    localparam int DIV_BPC = 1;

    // Container width for abs_n(); callers sign-extend into it and cast the
    // result back down to their own width.
    localparam int MAG_W = 64;

    function automatic logic [MAG_W-1:0] abs_n(input logic [MAG_W-1:0] v);
        return v[MAG_W-1] ? (-v) : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational restoring-division iteration on magnitudes.
//   rem      in  D_W+1  current partial remainder (always < dmag on entry)
//   n_bit    in  1      next dividend bit, MSB first
//   dmag     in  D_W    divisor magnitude
//   rem_next out D_W+1  partial remainder after this bit
//   q_bit    out 1      quotient bit for this position
// -----------------------------------------------------------------------------
module div_step #(
    parameter int D_W = 16
) (
    input  logic [D_W:0]   rem,
    input  logic           n_bit,
    input  logic [D_W-1:0] dmag,
    output logic [D_W:0]   rem_next,
    output logic           q_bit
);

    // Shifted remainder. Because rem < dmag, the result is < 2*dmag and so
    // fits in D_W+1 bits; the extra top bit only keeps the compare honest.
    logic [D_W+1:0] partial;

    assign partial  = {rem, n_bit};
    assign q_bit    = (partial >= {2'b00, dmag});
    assign rem_next = q_bit ? (partial[D_W:0] - {1'b0, dmag}) : partial[D_W:0];

endmodule

// File: rtl/div32via16_seq.sv
// -----------------------------------------------------------------------------
// div32via16_seq
// Sequential signed divider: N_W-bit dividend / D_W-bit divisor, producing an
// N_W-bit quotient (truncated toward zero) and a D_W-bit remainder carrying the
// sign of the dividend. Restoring division on magnitudes, BITS_PER_CYC quotient
// bits per CALC cycle.
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_valid/o_ready   operand handshake (o_ready high only in IDLE)
//   i_n, i_d          signed dividend / divisor
//   o_valid/i_ready   result handshake (o_valid high only in DONE)
//   o_q, o_r          signed quotient / remainder (registered, held until next result)
//   o_dbz, o_ovf      divide-by-zero and INT_MIN/-1 overflow flags
// -----------------------------------------------------------------------------
module div32via16_seq
    import div_pkg::*;
#(
    parameter int N_W          = DIV_N_W,
    parameter int D_W          = DIV_D_W,
    parameter int BITS_PER_CYC = DIV_BPC
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_valid,
    output logic           o_ready,
    input  logic [N_W-1:0] i_n,
    input  logic [D_W-1:0] i_d,
    output logic           o_valid,
    input  logic           i_ready,
    output logic [N_W-1:0] o_q,
    output logic [D_W-1:0] o_r,
    output logic           o_dbz,
    output logic           o_ovf
);

    localparam int ITERS = N_W / BITS_PER_CYC;
    localparam int CNT_W = $clog2(ITERS + 1);

    div_state_t     state_reg;
    // Dividend bits shift out of the top while quotient bits shift in at the
    // bottom; after ITERS cycles this register holds the quotient magnitude.
    logic [N_W-1:0] nq_reg;
    logic [D_W:0]   rem_reg;
    logic [D_W-1:0] dmag_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic           sign_q_reg;
    logic           sign_r_reg;
    logic           dbz_pend_reg;
    logic           ovf_pend_reg;

    // Operand decode at accept time
    logic [N_W-1:0] n_mag;
    logic [D_W-1:0] d_mag;
    logic           is_dbz;
    logic           is_ovf;

    assign n_mag  = N_W'(abs_n({{(MAG_W-N_W){i_n[N_W-1]}}, i_n}));
    assign d_mag  = D_W'(abs_n({{(MAG_W-D_W){i_d[D_W-1]}}, i_d}));
    assign is_dbz = (i_d == '0);
    assign is_ovf = (i_n == {1'b1, {(N_W-1){1'b0}}}) && (i_d == '1);

    // Chain of restoring steps evaluated in one CALC cycle
    logic [BITS_PER_CYC:0][D_W:0]   rem_chain;
    logic [BITS_PER_CYC:0][N_W-1:0] nq_chain;
    logic [BITS_PER_CYC-1:0]        q_bits;

    assign rem_chain[0] = rem_reg;
    assign nq_chain[0]  = nq_reg;

    for (genvar gi = 0; gi < BITS_PER_CYC; gi++) begin : g_step
        div_step #(
            .D_W (D_W)
        ) u_step (
            .rem      (rem_chain[gi]),
            .n_bit    (nq_chain[gi][N_W-1]),
            .dmag     (dmag_reg),
            .rem_next (rem_chain[gi+1]),
            .q_bit    (q_bits[gi])
        );
        assign nq_chain[gi+1] = {nq_chain[gi][N_W-2:0], q_bits[gi]};
    end

    // Sign fix-up applied once the counter has run out
    logic [N_W-1:0] q_fix;
    logic [D_W-1:0] r_fix;

    assign q_fix = sign_q_reg ? (-nq_reg) : nq_reg;
    assign r_fix = sign_r_reg ? (-rem_reg[D_W-1:0]) : rem_reg[D_W-1:0];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg    <= IDLE;
            nq_reg       <= '0;
            rem_reg      <= '0;
            dmag_reg     <= '0;
            cnt_reg      <= '0;
            sign_q_reg   <= 1'b0;
            sign_r_reg   <= 1'b0;
            dbz_pend_reg <= 1'b0;
            ovf_pend_reg <= 1'b0;
            o_ready      <= 1'b1;
            o_valid      <= 1'b0;
            o_q          <= '0;
            o_r          <= '0;
            o_dbz        <= 1'b0;
            o_ovf        <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (i_valid) begin
                        state_reg <= CALC;
                        o_ready   <= 1'b0;
                        o_dbz     <= 1'b0;
                        o_ovf     <= 1'b0;
                        rem_reg   <= '0;
                        dmag_reg  <= d_mag;
                        // Special cases skip the iterations: the counter starts
                        // at zero and the preloaded magnitudes pass straight
                        // through the fix-up cycle with both signs forced off.
                        if (is_dbz) begin
                            nq_reg       <= '0;
                            sign_q_reg   <= 1'b0;
                            sign_r_reg   <= 1'b0;
                            cnt_reg      <= '0;
                            dbz_pend_reg <= 1'b1;
                            ovf_pend_reg <= 1'b0;
                        end else if (is_ovf) begin
                            nq_reg       <= n_mag;   // 2^(N_W-1) reads back as INT_MIN
                            sign_q_reg   <= 1'b0;
                            sign_r_reg   <= 1'b0;
                            cnt_reg      <= '0;
                            dbz_pend_reg <= 1'b0;
                            ovf_pend_reg <= 1'b1;
                        end else begin
                            nq_reg       <= n_mag;
                            sign_q_reg   <= i_n[N_W-1] ^ i_d[D_W-1];
                            sign_r_reg   <= i_n[N_W-1];
                            cnt_reg      <= CNT_W'(ITERS);
                            dbz_pend_reg <= 1'b0;
                            ovf_pend_reg <= 1'b0;
                        end
                    end
                end

                CALC: begin
                    if (cnt_reg != '0) begin
                        nq_reg  <= nq_chain[BITS_PER_CYC];
                        rem_reg <= rem_chain[BITS_PER_CYC];
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end else begin
                        o_q       <= q_fix;
                        o_r       <= r_fix;
                        o_dbz     <= dbz_pend_reg;
                        o_ovf     <= ovf_pend_reg;
                        o_valid   <= 1'b1;
                        state_reg <= DONE;
                    end
                end

                DONE: begin
                    // Outputs hold until the consumer takes them; o_ready only
                    // rises on the way back to IDLE, so accept never coincides
                    // with transfer.
                    if (i_ready) begin
                        o_valid   <= 1'b0;
                        o_ready   <= 1'b1;
                        state_reg <= IDLE;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                    o_valid   <= 1'b0;
                    o_ready   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div32via16_seq.sv
// -----------------------------------------------------------------------------
// tb_div32via16_seq
// Directed vectors with hand-computed results plus a product round trip.
// The driver pushes expected results into a scoreboard queue; a separate
// monitor pops and compares on every result transfer, including latency.
// -----------------------------------------------------------------------------
module tb_div32via16_seq;

    parameter int BPC = 1;
    localparam int LAT_NORM = 32 / BPC + 1;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [31:0] i_n = '0;
    logic [15:0] i_d = '0;
    logic        o_valid;
    logic        i_ready = 1'b1;
    logic [31:0] o_q;
    logic [15:0] o_r;
    logic        o_dbz;
    logic        o_ovf;

    div32via16_seq #(
        .N_W          (32),
        .D_W          (16),
        .BITS_PER_CYC (BPC)
    ) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_n     (i_n),
        .i_d     (i_d),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_q     (o_q),
        .o_r     (o_r),
        .o_dbz   (o_dbz),
        .o_ovf   (o_ovf)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] q;
        logic [15:0] r;
        logic        dbz;
        logic        ovf;
        int          lat;
        int          acc;
        int          id;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   next_id = 0;

    initial forever begin
        @(posedge i_clk);
        cyc = cyc + 1;
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        vectors = vectors + 1;
        if (act !== req) begin
            miscompares = miscompares + 1;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on every result transfer
    initial begin : monitor
        bit   seen;
        int   first_valid;
        exp_t e;
        seen = 1'b0;
        first_valid = 0;
        forever begin
            @(negedge i_clk);
            if (o_valid && !seen) begin
                seen = 1'b1;
                first_valid = cyc;
            end
            if (o_valid && i_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_result", 64'(o_q), 64'hDEAD);
                end else begin
                    e = sb.pop_front();
                    check($sformatf("v%0d_q", e.id),   64'(o_q),   64'(e.q));
                    check($sformatf("v%0d_r", e.id),   64'(o_r),   64'(e.r));
                    check($sformatf("v%0d_dbz", e.id), 64'(o_dbz), 64'(e.dbz));
                    check($sformatf("v%0d_ovf", e.id), 64'(o_ovf), 64'(e.ovf));
                    check($sformatf("v%0d_lat", e.id), 64'(first_valid - e.acc), 64'(e.lat));
                    $display("result v%0d: q=%0h r=%0h dbz=%0b ovf=%0b lat=%0d",
                             e.id, o_q, o_r, o_dbz, o_ovf, first_valid - e.acc);
                end
                seen = 1'b0;
            end
        end
    end

    // Called in the phase just after a rising edge. Waits (bounded) for
    // o_ready, presents one operand pair, and optionally records the result.
    task automatic issue(input logic [31:0] n, input logic [15:0] d,
                         input logic [31:0] q, input logic [15:0] r,
                         input logic dbz, input logic ovf, input bit push);
        int   t;
        exp_t e;
        t = 0;
        while (!o_ready && t < 200) begin
            @(posedge i_clk); #1;
            t++;
        end
        if (!o_ready) begin
            check("ready_timeout", 64'(o_ready), 64'd1);
        end else begin
            i_n = n;
            i_d = d;
            i_valid = 1'b1;
            @(posedge i_clk); #1;
            i_valid = 1'b0;
            $display("issue v%0d: n=%0h d=%0h", next_id, n, d);
            check("flags_clear_on_accept", 64'({o_dbz, o_ovf}), 64'd0);
            if (push) begin
                e.q = q; e.r = r; e.dbz = dbz; e.ovf = ovf;
                e.lat = (dbz || ovf) ? 1 : LAT_NORM;
                e.acc = cyc;
                e.id  = next_id;
                sb.push_back(e);
            end
            next_id++;
        end
    endtask

    initial begin : driver
        int    t;
        int    vcnt;
        shortint a_s, b_s;
        int    ai, n;

        repeat (3) @(posedge i_clk);
        #1;
        check("rst_ready", 64'(o_ready), 64'd1);
        check("rst_valid", 64'(o_valid), 64'd0);
        check("rst_q",     64'(o_q),     64'd0);
        check("rst_r",     64'(o_r),     64'd0);
        check("rst_flags", 64'({o_dbz, o_ovf}), 64'd0);
        i_rst = 1'b0;
        @(posedge i_clk); #1;

        // Directed vectors
        issue(32'd1000000, -16'd123, 32'hFFFF_E03E, 16'd10, 1'b0, 1'b0, 1);
        issue(-32'd7, 16'd2,   -32'd3, -16'd1, 1'b0, 1'b0, 1);
        issue(32'd7,  -16'd2,  -32'd3, 16'd1,  1'b0, 1'b0, 1);
        issue(-32'd7, -16'd2,  32'd3,  -16'd1, 1'b0, 1'b0, 1);
        issue(32'h8000_0000, 16'hFFFF, 32'h8000_0000, 16'd0, 1'b0, 1'b1, 1);
        issue(32'd12345, 16'd0, 32'd0, 16'd0, 1'b1, 1'b0, 1);
        issue(32'd10, 16'd3, 32'd3, 16'd1, 1'b0, 1'b0, 1);
        issue(32'h8000_0000, 16'd1, 32'h8000_0000, 16'd0, 1'b0, 1'b0, 1);
        issue(32'h8000_0000, 16'h8000, 32'h0001_0000, 16'd0, 1'b0, 1'b0, 1);
        issue(32'h7FFF_FFFF, 16'h8000, 32'hFFFF_0001, 16'h7FFF, 1'b0, 1'b0, 1);
        issue(-32'd100, 16'd7, -32'd14, -16'd2, 1'b0, 1'b0, 1);
        issue(32'd5, 16'd7, 32'd0, 16'd5, 1'b0, 1'b0, 1);

        // Back-pressure: hold the result for 10 cycles while offering new operands
        t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(posedge i_clk); #1;
            t++;
        end
        check("drain_before_bp", 64'(sb.size()), 64'd0);
        i_ready = 1'b0;
        issue(32'd1000000, -16'd123, 32'hFFFF_E03E, 16'd10, 1'b0, 1'b0, 1);
        t = 0;
        while (!o_valid && t < 100) begin
            @(posedge i_clk); #1;
            t++;
        end
        check("bp_valid_seen", 64'(o_valid), 64'd1);
        i_n = 32'd99;
        i_d = 16'd9;
        i_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge i_clk); #1;
            check("bp_hold_valid", 64'(o_valid), 64'd1);
            check("bp_hold_ready", 64'(o_ready), 64'd0);
            check("bp_hold_q",     64'(o_q),     64'hFFFF_E03E);
            check("bp_hold_r",     64'(o_r),     64'd10);
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(posedge i_clk); #1;
        check("bp_back_to_idle", 64'({o_ready, o_valid}), 64'b10);

        // Reset during CALC: operation discarded, outputs cleared, no result
        issue(32'd1000, 16'd7, 32'd0, 16'd0, 1'b0, 1'b0, 0);
        repeat (4) begin
            @(posedge i_clk); #1;
        end
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        check("midrst_ready", 64'(o_ready), 64'd1);
        check("midrst_valid", 64'(o_valid), 64'd0);
        check("midrst_q",     64'(o_q),     64'd0);
        check("midrst_r",     64'(o_r),     64'd0);
        vcnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge i_clk); #1;
            if (o_valid) vcnt++;
        end
        check("midrst_no_result", 64'(vcnt), 64'd0);

        // Round trip: n = a*b, d = b recovers a exactly
        for (int k = 0; k < 200; k++) begin
            a_s = shortint'($urandom_range(0, 65535));
            do b_s = shortint'($urandom_range(0, 65535)); while (b_s == 0);
            ai = a_s;
            n  = ai * int'(b_s);
            issue(n, b_s, ai, 16'd0, 1'b0, 1'b0, 1);
        end

        t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(posedge i_clk); #1;
            t++;
        end
        check("final_drain", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
